// File: rtl/tama_stat_arbiter_pkg.sv
// Shared constants and saturating arithmetic for the pet stat file.
package tama_pkg;

    localparam int STAT_W  = 3;
    localparam int NUM_SRC = 5;

    localparam int SRC_FEED  = 0;
    localparam int SRC_SLEEP = 1;
    localparam int SRC_PLAY  = 2;
    localparam int SRC_HEAL  = 3;
    localparam int SRC_DECAY = 4;

    typedef logic [STAT_W-1:0] stat_t;

    localparam stat_t DELTA_FEED_FOOD   = 3'd2;
    localparam stat_t DELTA_FEED_HEALTH = 3'd1;
    localparam stat_t DELTA_SLEEP       = 3'd2;
    localparam stat_t DELTA_PLAY_FUN    = 3'd2;
    localparam stat_t DELTA_PLAY_FOOD   = 3'd1;
    localparam stat_t DELTA_HEAL        = 3'd2;
    localparam stat_t DELTA_DECAY       = 3'd1;

    function automatic stat_t sat_add(stat_t v, stat_t d, stat_t max_v);
        logic [STAT_W:0] sum;
        sum = {1'b0, v} + {1'b0, d};
        return (sum > {1'b0, max_v}) ? max_v : sum[STAT_W-1:0];
    endfunction

    function automatic stat_t sat_sub(stat_t v, stat_t d);
        return (v < d) ? '0 : v - d;
    endfunction

    function automatic stat_t stat_min(stat_t a, stat_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/tama_stat_arbiter_if.sv
// Event inputs and stat outputs of the stat arbiter, grouped as one bundle.
interface tama_stat_arbiter_if;
    import tama_pkg::*;

    logic               feeding;
    logic               light_out;
    logic               echo_sig;
    logic               healing;
    logic               testBut;
    stat_t              foodValue;
    stat_t              sleepValue;
    stat_t              funValue;
    stat_t              healthValue;
    stat_t              happyValue;
    logic [NUM_SRC-1:0] grant;
    logic               busy;

    modport master (
        output feeding, light_out, echo_sig, healing, testBut,
        input  foodValue, sleepValue, funValue, healthValue, happyValue, grant, busy
    );

    modport slave (
        input  feeding, light_out, echo_sig, healing, testBut,
        output foodValue, sleepValue, funValue, healthValue, happyValue, grant, busy
    );

endinterface

// File: rtl/tama_rr_arb5.sv
// Five-way round-robin arbiter; the pointer names the highest-priority request.
module tama_rr_arb5
    import tama_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NUM_SRC-1:0] i_req,
    output logic [NUM_SRC-1:0] o_grant
);

    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic       w_found;
    int         w_idx;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        o_grant   = '0;
        w_ptr_nxt = r_ptr;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int off = 0; off < NUM_SRC; off++) begin
            w_idx = (int'(r_ptr) + off) % NUM_SRC;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_ptr_nxt      = 3'((w_idx + 1) % NUM_SRC);
                w_found        = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst)
            r_ptr <= '0;
        else if (w_found)
            r_ptr <= w_ptr_nxt;
    end

endmodule

// File: rtl/tama_stat_arbiter.sv
// Serialises feed/sleep/play/heal/decay events into one saturating stat file,
// one round-robin grant per cycle.
module tama_stat_arbiter
    import tama_pkg::*;
#(
    parameter int STAT_MAX     = 5,
    parameter int STAT_INIT    = 5,
    parameter int DECAY_PERIOD = 50_000_000,
    parameter int TEST_DIV     = 1000
)(
    input  logic                Clk,
    input  logic                Rst,
    tama_stat_arbiter_if.slave  bus
);

    localparam int             CNT_W    = $clog2(DECAY_PERIOD);
    localparam logic [CNT_W-1:0] LIM_NORM = CNT_W'(DECAY_PERIOD - 1);
    localparam logic [CNT_W-1:0] LIM_TEST = CNT_W'(DECAY_PERIOD / TEST_DIV - 1);
    localparam stat_t          MAX_V    = STAT_W'(STAT_MAX);
    localparam stat_t          INIT_V   = STAT_W'(STAT_INIT);

    logic [3:0]         w_in;
    logic [3:0]         r_prev;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] w_grant;
    logic [NUM_SRC-1:0] r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_limit;
    logic               w_decay_hit;
    stat_t              r_food, r_sleep, r_fun, r_health, r_happy;
    stat_t              w_food_nxt, w_sleep_nxt, w_fun_nxt, w_health_nxt;

    assign w_in        = {bus.healing, bus.echo_sig, bus.light_out, bus.feeding};
    assign w_limit     = bus.testBut ? LIM_TEST : LIM_NORM;
    assign w_decay_hit = (r_cnt == w_limit);
    assign w_rise      = {w_decay_hit, w_in & ~r_prev};

    tama_rr_arb5 u_arb (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_req   (r_pend),
        .o_grant (w_grant)
    );

    // A counter stranded above a freshly lowered limit wraps silently.
    always_ff @(posedge Clk) begin
        if (Rst || r_cnt >= w_limit)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CNT_W'(1);
    end

    always_comb begin
        w_food_nxt   = r_food;
        w_sleep_nxt  = r_sleep;
        w_fun_nxt    = r_fun;
        w_health_nxt = r_health;
        if (w_grant[SRC_FEED]) begin
            w_food_nxt   = sat_add(r_food, DELTA_FEED_FOOD, MAX_V);
            w_health_nxt = sat_add(r_health, DELTA_FEED_HEALTH, MAX_V);
        end
        if (w_grant[SRC_SLEEP])
            w_sleep_nxt = sat_add(r_sleep, DELTA_SLEEP, MAX_V);
        if (w_grant[SRC_PLAY]) begin
            w_fun_nxt  = sat_add(r_fun, DELTA_PLAY_FUN, MAX_V);
            w_food_nxt = sat_sub(r_food, DELTA_PLAY_FOOD);
        end
        if (w_grant[SRC_HEAL])
            w_health_nxt = sat_add(r_health, DELTA_HEAL, MAX_V);
        if (w_grant[SRC_DECAY]) begin
            w_food_nxt   = sat_sub(r_food, DELTA_DECAY);
            w_sleep_nxt  = sat_sub(r_sleep, DELTA_DECAY);
            w_fun_nxt    = sat_sub(r_fun, DELTA_DECAY);
            w_health_nxt = sat_sub(r_health, DELTA_DECAY);
        end
    end

    // Previous samples track the live inputs even in reset, so held lines raise no event.
    always_ff @(posedge Clk) begin
        r_prev <= w_in;
        if (Rst) begin
            r_pend   <= '0;
            r_grant  <= '0;
            r_food   <= INIT_V;
            r_sleep  <= INIT_V;
            r_fun    <= INIT_V;
            r_health <= INIT_V;
            r_happy  <= INIT_V;
        end else begin
            r_pend   <= (r_pend & ~w_grant) | w_rise;
            r_grant  <= w_grant;
            r_food   <= w_food_nxt;
            r_sleep  <= w_sleep_nxt;
            r_fun    <= w_fun_nxt;
            r_health <= w_health_nxt;
            r_happy  <= stat_min(stat_min(r_food, r_sleep), stat_min(r_fun, r_health));
        end
    end

    assign bus.foodValue   = r_food;
    assign bus.sleepValue  = r_sleep;
    assign bus.funValue    = r_fun;
    assign bus.healthValue = r_health;
    assign bus.happyValue  = r_happy;
    assign bus.grant       = r_grant;
    assign bus.busy        = |r_pend;

endmodule

// File: tb/tb_tama_stat_arbiter.sv
// Directed scoreboard bench for tama_stat_arbiter: stimulus pushes expected grants,
// a monitor pops and compares every grant pulse with the stat file after it.
module tb_tama_stat_arbiter;
    import tama_pkg::*;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    tama_stat_arbiter_if bus_if ();

    tama_stat_arbiter #(
        .STAT_MAX     (5),
        .STAT_INIT    (5),
        .DECAY_PERIOD (2000),
        .TEST_DIV     (1000)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [4:0] g;
        stat_t      f, s, u, h;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] g, input stat_t f, input stat_t s, input stat_t u, input stat_t h);
        exp_t e;
        e.g = g; e.f = f; e.s = s; e.u = u; e.h = h;
        q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick(2);
        Rst = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) tick();
        check("queue_drained", q.size(), 0);
    endtask

    // Monitor: every grant pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (bus_if.grant != '0) begin
                if (q.size() == 0) begin
                    check("unexpected_grant", bus_if.grant, 0);
                end else begin
                    e = q.pop_front();
                    check("grant",  bus_if.grant,       e.g);
                    check("food",   bus_if.foodValue,   e.f);
                    check("sleep",  bus_if.sleepValue,  e.s);
                    check("fun",    bus_if.funValue,    e.u);
                    check("health", bus_if.healthValue, e.h);
                end
            end
        end
    end

    initial begin
        bus_if.feeding   = 1'b0;
        bus_if.light_out = 1'b0;
        bus_if.echo_sig  = 1'b0;
        bus_if.healing   = 1'b0;
        bus_if.testBut   = 1'b0;

        // Reset state and a single uncontended feed at saturation.
        do_reset();
        tick();
        check("rst_food",  bus_if.foodValue,  5);
        check("rst_happy", bus_if.happyValue, 5);
        check("rst_grant", bus_if.grant,      0);
        check("rst_busy",  bus_if.busy,       0);
        push(5'b00001, 5, 5, 5, 5);
        bus_if.feeding = 1'b1;
        tick();
        check("busy_after_edge", bus_if.busy, 1);
        tick();
        check("busy_after_grant", bus_if.busy, 0);
        bus_if.feeding = 1'b0;
        wait_drain();
        check("happy_sat", bus_if.happyValue, 5);

        // Four fast decays to 1, then feed+play+heal together from pointer 0.
        bus_if.testBut = 1'b1;
        do_reset();
        push(5'b10000, 4, 4, 4, 4);
        push(5'b10000, 3, 3, 3, 3);
        push(5'b10000, 2, 2, 2, 2);
        push(5'b10000, 1, 1, 1, 1);
        wait_drain();
        bus_if.testBut = 1'b0;
        tick();
        check("happy_after_decay", bus_if.happyValue, 1);
        push(5'b00001, 3, 1, 1, 2);
        push(5'b00100, 2, 1, 3, 2);
        push(5'b01000, 2, 1, 3, 4);
        bus_if.feeding  = 1'b1;
        bus_if.echo_sig = 1'b1;
        bus_if.healing  = 1'b1;
        tick();
        bus_if.feeding  = 1'b0;
        bus_if.echo_sig = 1'b0;
        bus_if.healing  = 1'b0;
        wait_drain();
        tick();
        check("happy_after_rr", bus_if.happyValue, 1);
        check("busy_idle_rr",   bus_if.busy,       0);

        // Mode switch with counter above the fast limit: silent wrap, then decay to 0 and hold.
        do_reset();
        tick(10);
        bus_if.testBut = 1'b1;
        push(5'b10000, 4, 4, 4, 4);
        push(5'b10000, 3, 3, 3, 3);
        push(5'b10000, 2, 2, 2, 2);
        push(5'b10000, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) push(5'b10000, 0, 0, 0, 0);
        wait_drain();
        bus_if.testBut = 1'b0;
        tick(2);
        check("happy_floor", bus_if.happyValue, 0);

        // Feed edge landing in its own grant cycle is served again.
        bus_if.testBut = 1'b1;
        do_reset();
        for (int v = 4; v >= 0; v--) push(5'b10000, stat_t'(v), stat_t'(v), stat_t'(v), stat_t'(v));
        wait_drain();
        bus_if.testBut = 1'b0;
        push(5'b00001, 2, 0, 0, 1);
        bus_if.feeding = 1'b1;
        tick();
        bus_if.feeding = 1'b0;
        wait_drain();
        push(5'b00010, 2, 2, 0, 1);
        push(5'b00001, 4, 2, 0, 2);
        push(5'b00001, 5, 2, 0, 3);
        bus_if.feeding   = 1'b1;
        bus_if.light_out = 1'b1;
        tick();
        bus_if.feeding   = 1'b0;
        tick();
        bus_if.feeding   = 1'b1;
        tick();
        bus_if.feeding   = 1'b0;
        bus_if.light_out = 1'b0;
        wait_drain();
        tick();
        check("happy_refeed", bus_if.happyValue, 0);

        // Held line through reset raises nothing; reset discards pending events.
        bus_if.feeding = 1'b1;
        do_reset();
        tick(4);
        check("held_no_busy", bus_if.busy, 0);
        push(5'b00100, 4, 5, 5, 5);
        bus_if.echo_sig = 1'b1;
        tick();
        bus_if.echo_sig = 1'b0;
        wait_drain();
        bus_if.light_out = 1'b1;
        bus_if.echo_sig  = 1'b1;
        bus_if.healing   = 1'b1;
        tick();
        check("three_pending", bus_if.busy, 1);
        Rst = 1'b1;
        tick();
        check("mid_rst_food",  bus_if.foodValue, 5);
        check("mid_rst_busy",  bus_if.busy,      0);
        check("mid_rst_grant", bus_if.grant,     0);
        Rst = 1'b0;
        tick(4);
        check("post_rst_busy", bus_if.busy, 0);
        check("post_rst_food", bus_if.foodValue, 5);
        bus_if.feeding   = 1'b0;
        bus_if.light_out = 1'b0;
        bus_if.echo_sig  = 1'b0;
        bus_if.healing   = 1'b0;
        tick(2);
        check("final_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
